// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: word geometry, command codes,
// FSM state encoding and bit-counter milestones.
package spi_pkg;

   localparam int WORD_W = 10;
   localparam int ADDR_W = 8;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   // Bit counter milestones inside a shift state: 0..8 receiving, 9 word sent,
   // 10 read data being serialised, 11 read data finished.
   localparam logic [3:0] CNT_LAST = 4'd8;
   localparam logic [3:0] CNT_WAIT = 4'd9;
   localparam logic [3:0] CNT_SEND = 4'd10;

   function automatic logic is_shift_state(input state_t s);
      logic r;
      case (s)
         WRITE, READ_ADD, READ_DATA: r = 1'b1;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-in/serial-out for read data; the output bit is registered
// and returns to 0 once all bits are sent or when cleared.
module spi_tx_serializer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [ADDR_W-1:0] din,
   output logic              sout,
   output logic              done
);

   localparam int CNT_W = $clog2(ADDR_W + 1);

   logic [ADDR_W-1:0] shreg_r;
   logic [CNT_W-1:0]  remain_r;
   logic              active_r;
   logic              sout_r;
   logic              done_r;

   // Load presents the MSB immediately; each following edge presents the next bit.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         shreg_r  <= {ADDR_W{1'b0}};
         remain_r <= {CNT_W{1'b0}};
         active_r <= 1'b0;
         sout_r   <= 1'b0;
         done_r   <= 1'b0;
      end else if (load) begin
         shreg_r  <= {din[ADDR_W-2:0], 1'b0};
         remain_r <= CNT_W'(ADDR_W - 1);
         active_r <= 1'b1;
         sout_r   <= din[ADDR_W-1];
         done_r   <= 1'b0;
      end else if (remain_r != {CNT_W{1'b0}}) begin
         shreg_r  <= {shreg_r[ADDR_W-2:0], 1'b0};
         remain_r <= remain_r - CNT_W'(1);
         sout_r   <= shreg_r[ADDR_W-1];
      end else if (active_r) begin
         active_r <= 1'b0;
         sout_r   <= 1'b0;
         done_r   <= 1'b1;
      end else begin
         sout_r   <= 1'b0;
      end
   end

   assign sout = sout_r;
   assign done = done_r;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises 10-bit command words for the RAM stage and
// serialises the RAM's read data back on MISO. SCK is the block clock.
module spi_slave_fsm #(
   parameter int WORD_W = 10,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [ADDR_W-1:0] tx_data,
   input  logic              tx_valid
);

   import spi_pkg::*;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [3:0]        bit_cnt_r;
   logic [WORD_W-2:0] shift_r;
   logic [WORD_W-1:0] rx_data_r;
   logic              rx_valid_r;
   logic              rd_addr_seen_r;
   logic              emit_s;
   logic              tx_load_s;
   logic              tx_clr_s;
   logic              tx_done_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus the word-complete and read-data-load strobes.
   always_comb begin
      state_nxt_s = state_r;
      emit_s      = 1'b0;
      tx_load_s   = 1'b0;
      tx_clr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (!SS_n) begin
               state_nxt_s = CHK_CMD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CHK_CMD: begin
            if (SS_n) begin
               state_nxt_s = IDLE;
               tx_clr_s    = 1'b1;
            end else if (!MOSI) begin
               state_nxt_s = WRITE;
            end else if (rd_addr_seen_r) begin
               state_nxt_s = READ_DATA;
            end else begin
               state_nxt_s = READ_ADD;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               state_nxt_s = IDLE;
               tx_clr_s    = 1'b1;
            end else if (bit_cnt_r == CNT_LAST) begin
               emit_s = 1'b1;
            end else if ((state_r == READ_DATA) && (bit_cnt_r == CNT_WAIT) && tx_valid) begin
               tx_load_s = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            tx_clr_s    = 1'b1;
         end
      endcase
   end

   // Receive shift register, bit counter, word hand-off and read-address flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_r      <= 4'd0;
         shift_r        <= {(WORD_W-1){1'b0}};
         rx_data_r      <= {WORD_W{1'b0}};
         rx_valid_r     <= 1'b0;
         rd_addr_seen_r <= 1'b0;
      end else begin
         rx_valid_r <= emit_s;
         if (state_r == CHK_CMD) begin
            shift_r   <= {{(WORD_W-2){1'b0}}, MOSI};
            bit_cnt_r <= 4'd0;
         end else if (is_shift_state(state_r)) begin
            if (bit_cnt_r <= CNT_LAST) begin
               shift_r   <= {shift_r[WORD_W-3:0], MOSI};
               bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (tx_load_s || ((bit_cnt_r == CNT_SEND) && tx_done_s)) begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
               bit_cnt_r <= bit_cnt_r;
            end
         end else begin
            bit_cnt_r <= 4'd0;
         end

         // The word is forwarded raw; the RAM decodes the command bits.
         if (emit_s) begin
            rx_data_r <= {shift_r, MOSI};
            if (state_r == READ_ADD) begin
               rd_addr_seen_r <= 1'b1;
            end else if (state_r == READ_DATA) begin
               rd_addr_seen_r <= 1'b0;
            end else begin
               rd_addr_seen_r <= rd_addr_seen_r;
            end
         end
      end
   end

   spi_tx_serializer #(
      .ADDR_W (ADDR_W)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .clr  (tx_clr_s),
      .load (tx_load_s),
      .din  (tx_data),
      .sout (MISO),
      .done (tx_done_s)
   );

   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed self-checking bench for spi_slave_fsm: write/read framing, routing
// by rd_addr_seen, aborts, ignored tx_valid and mid-frame reset.
module tb_spi_slave_fsm;

   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_slave_fsm dut (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [9:0] w, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         MOSI = w[9-i];
         tick();
      end
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
   endtask

   task automatic full_frame(input logic [9:0] w);
      SS_n = 1'b0;
      tick();
      send_bits(w, 0, 10);
   endtask

   task automatic pulse_tx(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
      checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_r, IDLE); end
   endtask

   task automatic test_write();
      full_frame({WR_ADDR, 8'h3C});
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wr_addr_valid: got %b want 1", rx_valid); end
      checks++; if (rx_data !== 10'h03C) begin errors++; $display("FAIL wr_addr_data: got %h want 03c", rx_data); end
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wr_addr_one_cycle: got %b want 0", rx_valid); end
      end_frame();
      full_frame({WR_DATA, 8'hA5});
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wr_data_valid: got %b want 1", rx_valid); end
      checks++; if (rx_data !== 10'h1A5) begin errors++; $display("FAIL wr_data_data: got %h want 1a5", rx_data); end
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wr_data_one_cycle: got %b want 0", rx_valid); end
      end_frame();
      checks++; if (dut.rd_addr_seen_r !== 1'b0) begin errors++; $display("FAIL wr_rd_seen: got %b want 0", dut.rd_addr_seen_r); end
   endtask

   task automatic test_read();
      logic [7:0] exp = 8'hA5;
      full_frame({RD_ADDR, 8'h3C});
      checks++; if (rx_data !== 10'h23C || rx_valid !== 1'b1) begin errors++; $display("FAIL rd_addr_word: got %b/%h want 1/23c", rx_valid, rx_data); end
      tick();
      end_frame();
      full_frame({RD_DATA, 8'h00});
      checks++; if (rx_data !== 10'h300 || rx_valid !== 1'b1) begin errors++; $display("FAIL rd_data_word: got %b/%h want 1/300", rx_valid, rx_data); end
      tick();
      tick();
      pulse_tx(8'hA5);
      for (int k = 0; k < 8; k++) begin
         checks++; if (MISO !== exp[7-k]) begin errors++; $display("FAIL rd_miso_bit%0d: got %b want %b", 7-k, MISO, exp[7-k]); end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_tail%0d: got %b want 0", k, MISO); end
         tick();
      end
      end_frame();
   endtask

   task automatic test_route();
      logic [9:0] words [3]  = '{10'h211, 10'h322, 10'h233};
      state_t     states [3] = '{READ_ADD, READ_DATA, READ_ADD};
      logic [7:0] miso_exp [3] = '{8'h00, 8'h81, 8'h00};
      logic [7:0] e;
      for (int f = 0; f < 3; f++) begin
         e = miso_exp[f];
         SS_n = 1'b0;
         tick();
         send_bits(words[f], 0, 1);
         checks++; if (dut.state_r !== states[f]) begin errors++; $display("FAIL route_state%0d: got %0d want %0d", f, dut.state_r, states[f]); end
         send_bits(words[f], 1, 9);
         checks++; if (rx_valid !== 1'b1 || rx_data !== words[f]) begin errors++; $display("FAIL route_word%0d: got %b/%h want 1/%h", f, rx_valid, rx_data, words[f]); end
         tick();
         pulse_tx(8'h81);
         for (int k = 0; k < 8; k++) begin
            checks++; if (MISO !== e[7-k]) begin errors++; $display("FAIL route_miso%0d_bit%0d: got %b want %b", f, 7-k, MISO, e[7-k]); end
            tick();
         end
         end_frame();
      end
   endtask

   task automatic test_abort();
      SS_n = 1'b0;
      tick();
      send_bits({WR_ADDR, 8'hF0}, 0, 5);
      SS_n = 1'b1;
      tick();
      checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL abort5_state: got %0d want %0d", dut.state_r, IDLE); end
      for (int k = 0; k < 10; k++) begin
         checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort5_valid%0d: got %b want 0", k, rx_valid); end
         tick();
      end
      SS_n = 1'b0;
      tick();
      send_bits({WR_DATA, 8'hC3}, 0, 9);
      MOSI = 1'b1;
      SS_n = 1'b1;
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_last_valid: got %b want 0", rx_valid); end
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_last_valid2: got %b want 0", rx_valid); end
      full_frame({WR_DATA, 8'h5A});
      checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h15A) begin errors++; $display("FAIL abort_next_word: got %b/%h want 1/15a", rx_valid, rx_data); end
      tick();
      end_frame();
   endtask

   task automatic test_tx_ignored();
      full_frame({WR_ADDR, 8'h77});
      tick();
      pulse_tx(8'hFF);
      for (int k = 0; k < 4; k++) begin
         checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL txign_miso%0d: got %b want 0", k, MISO); end
         checks++; if (dut.state_r !== WRITE) begin errors++; $display("FAIL txign_state%0d: got %0d want %0d", k, dut.state_r, WRITE); end
         tick();
      end
      end_frame();
   endtask

   task automatic test_reset_mid_read();
      checks++; if (dut.rd_addr_seen_r !== 1'b1) begin errors++; $display("FAIL rmr_pre_seen: got %b want 1", dut.rd_addr_seen_r); end
      full_frame({RD_DATA, 8'h00});
      tick();
      pulse_tx(8'hA5);
      tick();
      tick();
      checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL rmr_pre_miso: got %b want 1", MISO); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rmr_miso: got %b want 0", MISO); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid: got %b want 0", rx_valid); end
      checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL rmr_state: got %0d want %0d", dut.state_r, IDLE); end
      end_frame();
      full_frame({RD_ADDR, 8'h44});
      tick();
      end_frame();
      SS_n = 1'b0;
      tick();
      send_bits({RD_DATA, 8'h55}, 0, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      SS_n = 1'b1;
      checks++; if (dut.rd_addr_seen_r !== 1'b0) begin errors++; $display("FAIL rmr_seen_clr: got %b want 0", dut.rd_addr_seen_r); end
      tick();
      SS_n = 1'b0;
      tick();
      send_bits({RD_DATA, 8'h66}, 0, 1);
      checks++; if (dut.state_r !== READ_ADD) begin errors++; $display("FAIL rmr_route: got %0d want %0d", dut.state_r, READ_ADD); end
      send_bits({RD_DATA, 8'h66}, 1, 9);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h366) begin errors++; $display("FAIL rmr_word: got %b/%h want 1/366", rx_valid, rx_data); end
      tick();
      end_frame();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_route();
      test_abort();
      test_tx_ignored();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
